// File: rtl/dmem_wbuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf_if
//  Description : Core <-> data-memory port bundle. The core drives the request
//                (chip enable, write enable, byte address, store data) and
//                receives load data back in the same cycle.
//                master : core side    (drives ce/we/addr/data_i, reads data_o)
//                slave  : memory side  (reads request, drives data_o)
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_wbuf_if;
    logic        ce_i;    // access request
    logic        we_i;    // 1 = store, 0 = load
    logic [31:0] addr_i;  // byte address
    logic [31:0] data_i;  // store data
    logic [31:0] data_o;  // load data (combinational)

    modport master (output ce_i, output we_i, output addr_i, output data_i,
                    input  data_o);
    modport slave  (input  ce_i, input  we_i, input  addr_i, input  data_i,
                    output data_o);
endinterface
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf
//  Description : Word-addressed data RAM with a small posted-write buffer.
//                Stores enter a circular FIFO and drain into the array on
//                idle cycles (or on a store that finds the FIFO full). Loads
//                return combinationally, forwarding from the youngest
//                matching buffered store.
//                Build option: define DMEM_WBUF_EN to include the write
//                buffer; without it stores write the array directly and
//                wb_count_o is tied to zero.
//  Ports       : clk        - clock
//                rst        - asynchronous active-low reset
//                bus        - dmem_wbuf_if.slave request/response bundle
//                wb_count_o - number of buffered stores
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_wbuf #(
    parameter int ADDR_WIDTH = 10,
    parameter int WB_DEPTH   = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    dmem_wbuf_if.slave                     bus,
    output logic [$clog2(WB_DEPTH):0]      wb_count_o
);

    localparam int WORDS = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q [0:WORDS-1];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_load;
    logic                  is_store;
    logic                  is_idle;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

    assign idx      = bus.addr_i[ADDR_WIDTH+1:2];
    assign is_load  = bus.ce_i & ~bus.we_i;
    assign is_store = bus.ce_i &  bus.we_i;
    assign is_idle  = ~bus.ce_i;

`ifdef DMEM_WBUF_EN
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] idx_q [0:WB_DEPTH-1];
    logic [31:0]           dat_q [0:WB_DEPTH-1];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  drain;
    logic                  enq;
    logic [31:0]           rd_data;

    // A full buffer hit by a store drains the head on the same edge, so the
    // core never has to stall. Nothing moves while reset is held.
    assign enq   = rst & is_store;
    assign drain = rst & ((is_idle  & (count_q != '0)) |
                          (is_store & (count_q == CW'(WB_DEPTH))));
    assign count_d = count_q + CW'(enq) - CW'(drain);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                idx_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                idx_q[tail_q] <= idx;
                dat_q[tail_q] <= bus.data_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (drain) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (drain) begin
            mem_q[idx_q[head_q]] <= dat_q[head_q];
        end
    end

    // Walk occupied entries oldest -> youngest; the last hit wins, which
    // gives youngest-store forwarding.
    always_comb begin
        logic [PW-1:0] pos;
        rd_data = mem_q[idx];
        pos     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            pos = head_q + PW'(i);
            if ((CW'(i) < count_q) && (idx_q[pos] == idx)) begin
                rd_data = dat_q[pos];
            end
        end
    end

    assign bus.data_o = (rst && is_load) ? rd_data : 32'h0;
    assign wb_count_o = count_q;
`else
    always_ff @(posedge clk) begin
        if (rst && is_store) begin
            mem_q[idx] <= bus.data_i;
        end
    end

    assign bus.data_o = (rst && is_load) ? mem_q[idx] : 32'h0;
    assign wb_count_o = '0;
`endif

endmodule
`default_nettype wire
